// File: rtl/contador_ctrl_if.sv
// Signal bundle between the counter sequencing controller and its surroundings:
// raw buttons, the run-mode level and counter value in; command pulses and status out.
interface contador_ctrl_if #(
    parameter int WIDTH = 6
);
    logic             btn_inc;
    logic             btn_clr;
    logic             mode_auto;
    logic [WIDTH-1:0] count_in;
    logic             inc;
    logic             clr;
    logic             done;
    logic [1:0]       state;

    modport master (
        output btn_inc, btn_clr, mode_auto, count_in,
        input  inc, clr, done, state
    );

    modport slave (
        input  btn_inc, btn_clr, mode_auto, count_in,
        output inc, clr, done, state
    );
endinterface

// File: rtl/contador_ctrl.sv
// Sequencing controller for the lab up-counter: debounced increment/clear buttons,
// prescaled auto-run mode and a terminal-value stop, all with registered outputs.
module contador_ctrl #(
    parameter int WIDTH           = 6,
    parameter int MAX_COUNT       = 2**WIDTH-1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_DIV        = 50000000,
    parameter bit STOP_AT_MAX     = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    contador_ctrl_if.slave bus
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PS_W = $clog2(TICK_DIV);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AUTO = 2'd1,
        DONE = 2'd2
    } state_t;

    // An increment request at the terminal value parks the controller instead of wrapping.
    function automatic logic halt_at(input logic [WIDTH-1:0] cnt);
        return STOP_AT_MAX && (cnt == MAX_VAL);
    endfunction

    logic [1:0]      raw;
    logic [1:0]      sync_p0;
    logic [1:0]      sync_p1;
    logic [1:0]      lvl_p2;
    logic [1:0]      lvl_p3;
    logic [DB_W-1:0] dbc_p2 [2];

    logic inc_evt;
    logic clr_evt;
    logic tick;

    state_t          state_q;
    state_t          state_nxt;
    logic [PS_W-1:0] presc_q;
    logic [PS_W-1:0] presc_nxt;
    logic            inc_nxt;
    logic            clr_nxt;
    logic            inc_p4;
    logic            clr_p4;
    logic            done_p4;

    assign raw = {bus.btn_clr, bus.btn_inc};

    // Stages 0-1 synchronise, stage 2 holds the accepted (debounced) level per button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            lvl_p2  <= '0;
            lvl_p3  <= '0;
            for (int i = 0; i < 2; i++) begin
                dbc_p2[i] <= '0;
            end
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            lvl_p3  <= lvl_p2;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == lvl_p2[i]) begin
                    dbc_p2[i] <= '0;
                end else if (dbc_p2[i] == DB_LAST) begin
                    dbc_p2[i] <= '0;
                    lvl_p2[i] <= ~lvl_p2[i];
                end else begin
                    dbc_p2[i] <= dbc_p2[i] + 1'b1;
                end
            end
        end
    end

    // Stage 3: press events are rising edges of the accepted level; releases are silent.
    assign inc_evt = lvl_p2[0] & ~lvl_p3[0];
    assign clr_evt = lvl_p2[1] & ~lvl_p3[1];
    assign tick    = (state_q == AUTO) && (presc_q == PS_LAST);

    always_comb begin
        state_nxt = state_q;
        presc_nxt = presc_q;
        inc_nxt   = 1'b0;
        clr_nxt   = 1'b0;
        if (clr_evt) begin
            // A clear overrides any increment or tick arriving in the same cycle.
            clr_nxt   = 1'b1;
            presc_nxt = '0;
            state_nxt = bus.mode_auto ? AUTO : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.mode_auto) begin
                        state_nxt = AUTO;
                        presc_nxt = '0;
                    end else if (inc_evt) begin
                        if (halt_at(bus.count_in)) state_nxt = DONE;
                        else                       inc_nxt   = 1'b1;
                    end
                end
                AUTO: begin
                    if (!bus.mode_auto) begin
                        state_nxt = IDLE;
                        presc_nxt = '0;
                    end else if (tick) begin
                        presc_nxt = '0;
                        if (halt_at(bus.count_in)) state_nxt = DONE;
                        else                       inc_nxt   = 1'b1;
                    end else begin
                        presc_nxt = presc_q + 1'b1;
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                    presc_nxt = '0;
                end
            endcase
        end
    end

    // Stage 4: every output leaves the block from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            inc_p4  <= 1'b0;
            clr_p4  <= 1'b0;
            done_p4 <= 1'b0;
        end else begin
            state_q <= state_nxt;
            presc_q <= presc_nxt;
            inc_p4  <= inc_nxt;
            clr_p4  <= clr_nxt;
            done_p4 <= (state_nxt == DONE);
        end
    end

    assign bus.inc   = inc_p4;
    assign bus.clr   = clr_p4;
    assign bus.done  = done_p4;
    assign bus.state = state_q;

endmodule

// File: tb/tb_contador_ctrl.sv
// Bench for contador_ctrl driving a 6-bit counter: directed scenarios plus random
// button traffic compared against a transaction-level model of the counter/controller.
`timescale 1ns/1ps
module tb_contador_ctrl;
    localparam int W    = 6;
    localparam int D    = 4;
    localparam int T    = 3;
    localparam int MAXC = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    contador_ctrl_if #(.WIDTH(W)) bus  ();
    contador_ctrl_if #(.WIDTH(W)) bus2 ();

    contador_ctrl #(.WIDTH(W), .MAX_COUNT(MAXC), .DEBOUNCE_CYCLES(D), .TICK_DIV(T),
                    .STOP_AT_MAX(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
    contador_ctrl #(.WIDTH(W), .MAX_COUNT(63), .DEBOUNCE_CYCLES(D), .TICK_DIV(T),
                    .STOP_AT_MAX(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    logic [W-1:0] count, count2;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        count <= '0;
        else if (bus.clr) count <= '0;
        else if (bus.inc) count <= count + 1'b1;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         count2 <= '0;
        else if (bus2.clr) count2 <= '0;
        else if (bus2.inc) count2 <= count2 + 1'b1;
    end
    assign bus.count_in  = count;
    assign bus2.count_in = count2;

    int vectors = 0;
    int errors  = 0;
    int cyc = 0;
    int inc_seen = 0;
    int clr_seen = 0;
    int last_inc_cyc = -1;
    logic inc_prev = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            check_val("inc_clr_excl", 32'(bus.inc & bus.clr), 0);
            check_val("inc_back2back", 32'(bus.inc & inc_prev), 0);
            if (bus.inc) begin
                inc_seen++;
                last_inc_cyc = cyc;
            end
            if (bus.clr) clr_seen++;
            inc_prev = bus.inc;
        end
    end

    // which: 0 = increment button, 1 = clear button, 2 = both together
    task automatic press(input int which, input int len);
        @(negedge clk);
        if (which != 1) bus.btn_inc = 1'b1;
        if (which != 0) bus.btn_clr = 1'b1;
        repeat (len) @(posedge clk);
        @(negedge clk);
        bus.btn_inc = 1'b0;
        bus.btn_clr = 1'b0;
        repeat (D + 8) @(negedge clk);
    endtask

    int m_count;
    bit m_done;
    int i0, c0, e_inc, e_clr, kind, n_inc, prev_cyc, prev_val;
    bit hit;
    int seq [3] = '{63, 0, 1};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.btn_inc = 0; bus.btn_clr = 0; bus.mode_auto = 0;
        bus2.btn_inc = 0; bus2.btn_clr = 0; bus2.mode_auto = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_state", 32'(bus.state), 0);
        check_val("rst_inc", 32'(bus.inc), 0);
        check_val("rst_clr", 32'(bus.clr), 0);
        check_val("rst_done", 32'(bus.done), 0);

        // latency: inc must appear after the 7th edge of the press
        @(negedge clk);
        c0 = cyc; i0 = inc_seen;
        bus.btn_inc = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.btn_inc = 1'b0;
        repeat (D + 8) @(negedge clk);
        check_val("lat_edge", 32'(last_inc_cyc - c0), 7);
        check_val("lat_pulses", 32'(inc_seen - i0), 1);
        check_val("lat_count", 32'(count), 1);

        i0 = inc_seen;
        press(0, 3);
        check_val("glitch_inc", 32'(inc_seen - i0), 0);
        check_val("glitch_count", 32'(count), 1);

        press(1, D);
        check_val("clr0_count", 32'(count), 0);
        for (int k = 0; k < 5; k++) press(0, D + 1);
        check_val("five_count", 32'(count), 5);
        i0 = inc_seen;
        press(0, D + 1);
        check_val("six_state", 32'(bus.state), 2);
        check_val("six_done", 32'(bus.done), 1);
        check_val("six_inc", 32'(inc_seen - i0), 0);
        check_val("six_count", 32'(count), 5);
        c0 = clr_seen;
        press(1, D + 2);
        check_val("clrdone_pulses", 32'(clr_seen - c0), 1);
        check_val("clrdone_count", 32'(count), 0);
        check_val("clrdone_state", 32'(bus.state), 0);
        check_val("clrdone_done", 32'(bus.done), 0);

        // back into DONE, then an asynchronous reset between clock edges
        for (int k = 0; k < 6; k++) press(0, D);
        check_val("redone_done", 32'(bus.done), 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("areset_done", 32'(bus.done), 0);
        check_val("areset_state", 32'(bus.state), 0);
        check_val("areset_inc", 32'(bus.inc), 0);
        check_val("areset_clr", 32'(bus.clr), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        inc_prev = 1'b0;
        repeat (2) @(negedge clk);
        check_val("post_rst_state", 32'(bus.state), 0);

        // auto-run from 0 up to the terminal value
        bus.mode_auto = 1'b1;
        n_inc = 0; prev_cyc = -1; hit = 0;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(negedge clk);
            if (bus.inc) begin
                if (prev_cyc >= 0) check_val("auto_gap", 32'(cyc - prev_cyc), T);
                prev_cyc = cyc;
                n_inc++;
            end
            if (bus.done) hit = 1;
        end
        check_val("auto_reached_done", 32'(hit), 1);
        check_val("auto_incs", 32'(n_inc), 5);
        check_val("auto_count", 32'(count), 5);
        check_val("auto_state", 32'(bus.state), 2);
        bus.mode_auto = 1'b0;
        press(1, D);
        check_val("auto_clr_state", 32'(bus.state), 0);
        check_val("auto_clr_count", 32'(count), 0);

        // leave auto-run as soon as the count shows 2
        bus.mode_auto = 1'b1;
        hit = 0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clk);
            if (count == 2) begin
                bus.mode_auto = 1'b0;
                hit = 1;
            end
        end
        check_val("stop_reached2", 32'(hit), 1);
        repeat (10) @(negedge clk);
        check_val("stop_count", 32'(count), 2);
        check_val("stop_state", 32'(bus.state), 0);

        // simultaneous clear and increment at count 3
        press(0, D);
        check_val("sim_pre_count", 32'(count), 3);
        i0 = inc_seen; c0 = clr_seen;
        press(2, D + 2);
        repeat (10) @(negedge clk);
        check_val("sim_inc", 32'(inc_seen - i0), 0);
        check_val("sim_clr", 32'(clr_seen - c0), 1);
        check_val("sim_count", 32'(count), 0);
        check_val("sim_state", 32'(bus.state), 0);

        // random button traffic against the transaction model
        m_count = 0; m_done = 0;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            i0 = inc_seen; c0 = clr_seen; e_inc = 0; e_clr = 0;
            if (kind <= 5) begin
                press(0, $urandom_range(D, D + 5));
                if (!m_done) begin
                    if (m_count == MAXC) m_done = 1;
                    else begin m_count++; e_inc = 1; end
                end
            end else if (kind == 6) begin
                press(0, $urandom_range(1, D - 1));
            end else if (kind <= 8) begin
                press(1, $urandom_range(D, D + 5));
                m_count = 0; m_done = 0; e_clr = 1;
            end else begin
                press(1, $urandom_range(1, D - 1));
            end
            check_val("rnd_count", 32'(count), m_count);
            check_val("rnd_state", 32'(bus.state), m_done ? 2 : 0);
            check_val("rnd_done", 32'(bus.done), 32'(m_done));
            check_val("rnd_inc", 32'(inc_seen - i0), e_inc);
            check_val("rnd_clr", 32'(clr_seen - c0), e_clr);
        end

        // wrap-around instance: auto-run through 63 -> 0 -> 1
        bus2.mode_auto = 1'b1;
        hit = 0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(negedge clk);
            if (count2 == 62) hit = 1;
        end
        check_val("wrap_reach62", 32'(hit), 1);
        for (int s = 0; s < 3; s++) begin
            prev_val = count2;
            hit = 0;
            for (int k = 0; k < 10 && !hit; k++) begin
                @(negedge clk);
                if (count2 != prev_val) hit = 1;
            end
            check_val("wrap_step", 32'(count2), seq[s]);
            check_val("wrap_done", 32'(bus2.done), 0);
        end
        check_val("wrap_state", 32'(bus2.state), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/contador_ctrl.md
Name: contador_ctrl

Overview:
Sequencing controller for the parameterised up-counter (`clk`, `reset`, `increment`, `count`) on the lab FPGA. It turns two raw push-buttons (increment, clear) into clean single-cycle command pulses. It also offers an auto-run mode driven by a prescaler tick and stops the counter at a programmable terminal value. Its outputs drive the counter's `increment` input and a synchronous clear; it observes the counter's `count` value.

Parameters:
- `WIDTH`, 6, width of the controlled counter and of `count_in`.
- `MAX_COUNT`, 2**WIDTH-1, terminal value; must be ≤ 2**WIDTH-1.
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles before a button level is accepted; must be ≥ 1.
- `TICK_DIV`, 50000000, clock cycles per auto-run increment; must be ≥ 2.
- `STOP_AT_MAX`, 1, 1 = halt in DONE at `MAX_COUNT`; 0 = keep issuing increments so the counter wraps.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_inc`  in  1  raw increment button, active-high, asynchronous to `clk`.
- `btn_clr`  in  1  raw clear button, active-high, asynchronous to `clk`.
- `mode_auto`  in  1  level; 1 = auto-run requested.
- `count_in`  in  `WIDTH`  current counter value.
- `inc`  out  1  one-cycle increment pulse to the counter.
- `clr`  out  1  one-cycle clear pulse to the counter.
- `done`  out  1  high while in DONE.
- `state`  out  2  IDLE=0, AUTO=1, DONE=2.

Behaviour:
- Reset (async, active-high):
  - `inc`=0, `clr`=0, `done`=0, `state`=IDLE.
  - Synchronisers, accepted button levels, debounce counters and prescaler all cleared to 0.
- All outputs are registered.
- Input path, per button:
  - 2-FF synchroniser.
  - Debounce counter increments on each edge where the synchronised level ≠ the accepted level, and clears when they are equal.
  - On reaching `DEBOUNCE_CYCLES`, the accepted level flips and the counter clears.
  - A press event is a 0→1 transition of the accepted level (one cycle). Releases produce no event.
- Latency: `btn_inc` first sampled high at edge 1 and held → `inc`=1 after edge `DEBOUNCE_CYCLES`+3, for exactly one cycle. `btn_clr` → `clr` has identical latency.
- Glitches shorter than `DEBOUNCE_CYCLES` produce no event.
- A button held high through reset release produces one event after the normal latency.
- IDLE:
  - inc event with `count_in` ≠ `MAX_COUNT` → `inc` pulse.
  - inc event with `count_in` = `MAX_COUNT`: if `STOP_AT_MAX`=1 → DONE, no `inc`; if 0 → `inc` pulse (counter wraps to 0).
  - `mode_auto`=1 → AUTO, prescaler cleared.
- AUTO:
  - Prescaler counts 0..`TICK_DIV`-1; the tick fires at terminal value, then the prescaler wraps.
  - On a tick, apply the same `MAX_COUNT` rule as an IDLE inc event.
  - Button inc events are ignored.
  - `mode_auto`=0 → IDLE, prescaler cleared, no pending tick.
- DONE:
  - `done`=1; no `inc` issued; inc events and ticks ignored.
  - Exit only via a clear event.
- Clear event, any state:
  - `clr` pulse for 1 cycle; `inc` forced 0 that cycle.
  - Prescaler cleared; `done`=0.
  - Next state = AUTO if `mode_auto`=1, else IDLE.
- Simultaneous clear and inc events (or tick) in the same cycle → clear wins; the inc is dropped, not queued.
- `count_in` is compared only on event/tick cycles. `TICK_DIV` ≥ 2 guarantees the counter has updated before the next comparison.
- `inc` and `clr` are never high in the same cycle. `inc` never pulses on two consecutive cycles.

Test Plan:
- Settings: `WIDTH`=6, `DEBOUNCE_CYCLES`=4, `TICK_DIV`=3, `STOP_AT_MAX`=1, `MAX_COUNT`=5, controller wired to a real 6-bit counter.
- Reset mid-run → outputs 0 immediately, asynchronously. Release with buttons low → `state`=IDLE, `inc`/`clr`/`done`=0.
- `btn_inc` high 10 cycles → exactly one `inc` at edge 7, count=1. 3-cycle glitch → no `inc`, count unchanged.
- Five clean presses → count=5. Sixth press → `state`=DONE, `done`=1, no `inc`, count stays 5. `btn_clr` press → one `clr`, count=0, `state`=IDLE, `done`=0.
- `mode_auto`=1 from count 0 → `inc` every 3rd cycle, count 1..5, then DONE. `mode_auto`=0 mid-run at count 2 → IDLE, count holds at 2.
- `btn_inc` and `btn_clr` pressed on the same edge at count 3 → `clr` only, count=0, no `inc` in the following 10 cycles.
- With `STOP_AT_MAX`=0 and `MAX_COUNT`=63, auto-run from 62 → count 63, then 0, then 1; `done` stays 0.
